// File: rtl/tpu_result_drain.sv
// Result drain: reads per-batch output SRAMs in batch-major, row-major
// order and streams rows on valid/ready through a 3-entry credit FIFO.
// Ports: clk, srst (sync, active-high), start pulse; per-batch SRAM
// read address/data buses; out_valid/out_ready beat handshake with
// out_data, out_batch, out_row, out_last tags; busy level, done pulse.
module tpu_result_drain #(
    parameter int ARRAY_SIZE     = 8,
    parameter int OUT_DATA_WIDTH = 16,
    parameter int BATCH_SIZE     = 3,
    parameter int MATRIX_BITS    = 4,
    parameter int ROW_COUNT      = 8,
    localparam int BW = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1,
    localparam int RW = ARRAY_SIZE * OUT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             start,
    output logic [BATCH_SIZE*MATRIX_BITS-1:0] sram_raddr_c_packed,
    input  logic [BATCH_SIZE*RW-1:0]         sram_rdata_c_packed,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RW-1:0]                    out_data,
    output logic [BW-1:0]                    out_batch,
    output logic [MATRIX_BITS-1:0]           out_row,
    output logic                             out_last,
    output logic                             busy,
    output logic                             done
);

    localparam int MB    = MATRIX_BITS;
    localparam int DEPTH = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [BW-1:0]          batch_cnt;
    logic [MB-1:0]          row_cnt;
    logic                   row_end, batch_end;
    logic                   issue, last_issue;
    logic                   inflight;
    logic [BW-1:0]          tag_batch;
    logic [MB-1:0]          tag_row;
    logic                   tag_last;
    logic [BATCH_SIZE*MB-1:0] raddr_q, raddr_nx;

    logic [RW-1:0] mem_data  [DEPTH];
    logic [BW-1:0] mem_batch [DEPTH];
    logic [MB-1:0] mem_row   [DEPTH];
    logic          mem_last  [DEPTH];
    logic [1:0]    wr_ptr, rd_ptr, count;
    logic          push, pop;

    assign row_end   = (row_cnt == MB'(ROW_COUNT - 1));
    assign batch_end = (batch_cnt == BW'(BATCH_SIZE - 1));

    // Credit counts the in-flight read so the FIFO can never overflow;
    // the pre-pop count keeps out_ready off the issue path.
    assign issue = (state == S_ISSUE) &&
                   (({1'b0, count} + {2'b00, inflight}) < 3'd3);
    assign last_issue = issue && row_end && batch_end;

    assign push      = inflight;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    assign out_data  = mem_data[rd_ptr];
    assign out_batch = mem_batch[rd_ptr];
    assign out_row   = mem_row[rd_ptr];
    assign out_last  = out_valid && mem_last[rd_ptr];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Address is presented combinationally in the issue cycle so the
    // SRAM returns data one cycle later; idle slices keep their value.
    always_comb begin
        raddr_nx = raddr_q;
        if (issue) begin
            raddr_nx[batch_cnt*MB +: MB] = row_cnt;
        end
    end

    assign sram_raddr_c_packed = raddr_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_ISSUE;
            S_ISSUE: if (last_issue) state_nx = S_FLUSH;
            // Leave FLUSH as the final beat transfers so done lands
            // on the very next cycle.
            S_FLUSH: begin
                if (!inflight &&
                    ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= S_IDLE;
            batch_cnt <= '0;
            row_cnt   <= '0;
            raddr_q   <= '0;
            inflight  <= 1'b0;
            tag_batch <= '0;
            tag_row   <= '0;
            tag_last  <= 1'b0;
        end else begin
            state    <= state_nx;
            raddr_q  <= raddr_nx;
            inflight <= issue;
            if (state == S_IDLE && start) begin
                batch_cnt <= '0;
                row_cnt   <= '0;
            end else if (issue) begin
                tag_batch <= batch_cnt;
                tag_row   <= row_cnt;
                tag_last  <= row_end && batch_end;
                if (row_end) begin
                    row_cnt   <= '0;
                    batch_cnt <= batch_end ? '0 : batch_cnt + 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= '0;
                mem_batch[i] <= '0;
                mem_row[i]   <= '0;
                mem_last[i]  <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]  <= sram_rdata_c_packed[tag_batch*RW +: RW];
                mem_batch[wr_ptr] <= tag_batch;
                mem_row[wr_ptr]   <= tag_row;
                mem_last[wr_ptr]  <= tag_last;
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Bench for tpu_result_drain: SRAM models, scoreboard of expected beats,
// directed timing/stall/reset steps and a 1x1 parameter instance.
module tb_tpu_result_drain;

    localparam int N  = 24;
    localparam int RW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          srst, start, out_ready;
    logic [11:0]   raddr;
    logic [3*RW-1:0] rdata;
    logic          out_valid, out_last, busy, done;
    logic [RW-1:0] out_data;
    logic [1:0]    out_batch;
    logic [3:0]    out_row;

    logic          s_start, s_out_ready;
    logic [3:0]    s_raddr;
    logic [RW-1:0] s_rdata;
    logic          s_out_valid, s_out_last, s_busy, s_done;
    logic [RW-1:0] s_out_data;
    logic [0:0]    s_out_batch;
    logic [3:0]    s_out_row;

    tpu_result_drain dut (
        .clk(clk), .srst(srst), .start(start),
        .sram_raddr_c_packed(raddr),
        .sram_rdata_c_packed(rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_batch(out_batch),
        .out_row(out_row), .out_last(out_last),
        .busy(busy), .done(done)
    );

    tpu_result_drain #(.BATCH_SIZE(1), .ROW_COUNT(1)) dut1 (
        .clk(clk), .srst(srst), .start(s_start),
        .sram_raddr_c_packed(s_raddr),
        .sram_rdata_c_packed(s_rdata),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_batch(s_out_batch),
        .out_row(s_out_row), .out_last(s_out_last),
        .busy(s_busy), .done(s_done)
    );

    function automatic logic [RW-1:0] row_val(input int b, input int r);
        logic [15:0] e;
        e = {b[7:0], r[7:0]};
        return {8{e}};
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < 3; b++)
            rdata[b*RW +: RW] <= row_val(b, int'(raddr[b*4 +: 4]));
        s_rdata <= row_val(0, int'(s_raddr));
    end

    typedef struct packed {
        logic [RW-1:0] d;
        logic [1:0]    b;
        logic [3:0]    r;
        logic          l;
    } beat_t;

    beat_t q[$];
    int checks = 0;
    int passed = 0;
    int nbeats = 0;
    int ndone  = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs,
                         input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    logic          pv = 1'b0, pr = 1'b0, psr = 1'b1;
    logic [RW-1:0] pd;
    logic [5:0]    ptag;

    always @(negedge clk) begin
        beat_t e;
        if (out_valid && out_ready) begin
            check("beat_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("beat_data", out_data, e.d);
                check("beat_batch", out_batch, e.b);
                check("beat_row", out_row, e.r);
                check("beat_last", out_last, e.l);
            end
            nbeats++;
        end
        if (done) begin
            check("done_q_empty", q.size(), 0);
            ndone++;
        end
        if (!psr && pv && !pr) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, pd);
            check("hold_tag", {out_batch, out_row}, ptag);
        end
        pv   <= out_valid;
        pr   <= out_ready;
        psr  <= srst;
        pd   <= out_data;
        ptag <= {out_batch, out_row};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick;
    endtask

    task automatic push_exp;
        for (int b = 0; b < 3; b++)
            for (int r = 0; r < 8; r++)
                q.push_back('{row_val(b, r), 2'(b), 4'(r),
                              (b == 2 && r == 7)});
    endtask

    task automatic kick(output int t0);
        start = 1'b1;
        t0 = cyc;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int bound,
                             input string tag);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check(tag, done, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        int t0, b0, d0;
        srst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        s_start = 1'b0;
        s_out_ready = 1'b1;
        tick; tick; tick;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_tag", {out_batch, out_row}, 0);
        check("rst_raddr", raddr, 0);
        srst = 1'b0;
        tick;

        // nominal full-rate drain
        push_exp();
        b0 = nbeats;
        kick(t0);
        check("t1_busy", busy, 1);
        check("t1_raddr", raddr, 0);
        check("t1_valid", out_valid, 0);
        wait_cyc(t0 + 3);
        check("t3_valid", out_valid, 1);
        check("t3_row", out_row, 0);
        wait_cyc(t0 + 2 + N);
        check("last_beat_flag", out_last, 1);
        check("no_early_done", done, 0);
        wait_cyc(t0 + 3 + N);
        check("done_time", done, 1);
        check("nom_beats", nbeats - b0, N);
        wait_cyc(t0 + 4 + N);
        check("busy_drop", busy, 0);
        check("done_pulse", done, 0);

        // stall from beat 2 for 10 cycles
        push_exp();
        b0 = nbeats;
        kick(t0);
        wait_cyc(t0 + 5);
        out_ready = 1'b0;
        wait_cyc(t0 + 10);
        check("stall_raddr", raddr, 12'h774);
        check("stall_valid", out_valid, 1);
        check("stall_row", out_row, 2);
        wait_cyc(t0 + 15);
        check("stall_beats", nbeats - b0, 2);
        check("stall_raddr_end", raddr, 12'h774);
        out_ready = 1'b1;
        wait_cyc(t0 + 2 + N + 10);
        check("stall_no_done", done, 0);
        wait_cyc(t0 + 3 + N + 10);
        check("stall_done_time", done, 1);
        check("stall_total", nbeats - b0, N);
        tick;

        // random backpressure, 5 back-to-back drains
        b0 = nbeats;
        for (int k = 0; k < 5; k++) begin
            push_exp();
            kick(t0);
            wait_done(1'b1, 400, "rand_done");
            tick;
        end
        check("rand_beats", nbeats - b0, 5 * N);
        check("rand_q_empty", q.size(), 0);

        // start re-pulsed mid-drain is ignored
        push_exp();
        b0 = nbeats;
        d0 = ndone;
        kick(t0);
        wait_cyc(t0 + 8);
        start = 1'b1;
        tick;
        start = 1'b0;
        wait_cyc(t0 + 3 + N + 6);
        check("restart_beats", nbeats - b0, N);
        check("restart_done", ndone - d0, 1);
        check("restart_idle", busy, 0);

        // reset mid-drain
        push_exp();
        d0 = ndone;
        kick(t0);
        wait_cyc(t0 + 13);
        srst = 1'b1;
        tick;
        srst = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_raddr", raddr, 0);
        check("abort_data", out_data, 0);
        q.delete();
        repeat (30) tick;
        check("abort_no_done", ndone - d0, 0);
        push_exp();
        b0 = nbeats;
        kick(t0);
        wait_done(1'b0, 100, "post_abort_done");
        check("post_abort_beats", nbeats - b0, N);
        tick;

        // single-beat instance
        s_start = 1'b1;
        t0 = cyc;
        tick;
        s_start = 1'b0;
        check("s_busy", s_busy, 1);
        wait_cyc(t0 + 3);
        check("s_valid", s_out_valid, 1);
        check("s_last", s_out_last, 1);
        check("s_data", s_out_data, row_val(0, 0));
        check("s_no_done", s_done, 0);
        wait_cyc(t0 + 4);
        check("s_done", s_done, 1);
        check("s_empty", s_out_valid, 0);
        wait_cyc(t0 + 5);
        check("s_idle", s_busy, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tpu_result_drain.md
# tpu_result_drain

Downstream readout stage for the systolic TPU. After the array signals completion, this block reads the per-batch output SRAMs (one SRAM per batch, ARRAY_SIZE*OUT_DATA_WIDTH bits per row) in batch-major, row-major order. It streams each row out on a valid/ready interface with batch/row tags and a last flag. A small credit-controlled FIFO absorbs the SRAM's 1-cycle read latency, so the block sustains one beat per cycle under continuous ready and loses nothing under backpressure.

## Interface
- ARRAY_SIZE, 8: PEs per row; a row holds ARRAY_SIZE results.
- OUT_DATA_WIDTH, 16: bits per result element.
- BATCH_SIZE, 3: number of output SRAMs to drain.
- MATRIX_BITS, 4: output SRAM address width.
- ROW_COUNT, 8: rows read per batch, addresses 0..ROW_COUNT-1; must be ≤ 2**MATRIX_BITS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse (driven by tpu_done) that begins a drain.
- sram_raddr_c_packed  out  BATCH_SIZE*MATRIX_BITS  read address per batch SRAM; slice b = [b*MATRIX_BITS +: MATRIX_BITS].
- sram_rdata_c_packed  in  BATCH_SIZE*ARRAY_SIZE*OUT_DATA_WIDTH  read data per batch SRAM. Data is valid the cycle after its address is presented.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  ARRAY_SIZE*OUT_DATA_WIDTH  one SRAM row, passed unmodified.
- out_batch  out  $clog2(BATCH_SIZE) (min 1)  batch index of the beat.
- out_row  out  MATRIX_BITS  row address of the beat.
- out_last  out  1  high on the final beat (batch BATCH_SIZE-1, row ROW_COUNT-1).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last beat transfers.

## Operation
- FSM states:
  - IDLE: waits for start.
  - ISSUE: generating reads.
  - FLUSH: all reads issued; waiting for the FIFO and the in-flight read to empty.
  - DONE: one cycle, asserts done, then returns to IDLE.
- Transitions:
  - IDLE→ISSUE on start; batch and row counters clear to 0.
  - ISSUE→FLUSH when read (BATCH_SIZE-1, ROW_COUNT-1) issues.
  - FLUSH→DONE when FIFO is empty, no read is in flight, and no transfer is pending.
- Read issue rule: issue when state is ISSUE and fifo_count + inflight < 3. fifo_count is the count before this cycle's pop.
  - On issue: drive the current row on the selected batch's address slice; all other slices hold their previous value.
  - Set inflight; record the (batch, row) tag in a 1-deep pipeline register.
  - Advance row; on row wrap (ROW_COUNT-1→0), advance batch.
- The cycle after an issue, the selected batch's rdata slice and its tag push into a 3-entry FIFO.
- The FIFO head drives out_data, out_batch, out_row, and out_last.
- Push and pop in the same cycle leave the count unchanged. The FIFO never overflows; the credit rule guarantees this.
- start while busy is ignored.
- No data is reordered or dropped; beats are emitted strictly in issue order.

## Timing
- Reset values: out_valid 0, busy 0, done 0, out_last 0, out_data 0, out_batch 0, out_row 0, all raddr slices 0. FIFO emptied, inflight cleared, FSM in IDLE.
- srst in any state, including mid-drain, aborts immediately to these values. Pending beats are discarded and done does not pulse.
- Let cycle T be the cycle in which start is sampled high:
  - T+1: busy=1; first address (batch 0, row 0) on slice 0.
  - T+2: rdata captured into the FIFO.
  - T+3: out_valid=1 with beat (0,0).
- With out_ready held high, beats transfer on consecutive cycles T+3 … T+2+N, where N = BATCH_SIZE*ROW_COUNT.
  - done pulses at T+3+N.
  - busy drops at T+4+N.
- Backpressure: with out_ready low, out_valid and data stay stable. Issue halts once fifo_count + inflight reaches 3, and the address outputs hold.
- out_valid must not depend combinationally on out_ready.

## Test plan
- Nominal: load row r of SRAM b with every element = {b[7:0], r[7:0]}; start with out_ready=1 → 24 beats at T+3..T+26 in order (0,0)…(2,7), data matching. out_last only on (2,7); done at T+27.
- Stall: out_ready low from beat 2 for 10 cycles → exactly 3 beats buffered, addresses frozen, no beat lost or duplicated. Full rate resumes after release.
- Random backpressure: out_ready 50% random over 5 back-to-back drains → scoreboard sees 120 beats in exact order; FIFO count never exceeds 3.
- start pulsed at beat 5 of a drain → ignored; exactly 24 beats and a single done pulse.
- srst asserted at beat 10 → next cycle out_valid=0, busy=0, no done. A new start then yields a full 24-beat drain from (0,0).
- Parameter sweep BATCH_SIZE=1, ROW_COUNT=1 → one beat with out_last=1 at T+3, done at T+4.
